// File: rtl/seg7_decode.sv
// Debounced seven-segment pattern decoder: synchronizes seg, waits for a stable pattern, then locks hex/valid/blank/err.
// Optional error-lock counter enabled by defining SEG7_DECODE_ERRCNT_EN.
module seg7_decode #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg,
  output logic [3:0]       hex,
  output logic             valid,
  output logic             blank,
  output logic             err,
  output logic             upd
`ifdef SEG7_DECODE_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  typedef enum logic {SETTLE, LOCKED} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] LOCK_AT = 4'(STABLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [6:0] s1, p, p_prev;
  logic [2:0] sv;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] hex_nxt;
  logic       valid_nxt, blank_nxt, err_nxt, upd_nxt;
  logic       chg;
  logic [4:0] dec;

  // {legal, digit}; anything outside the table decodes as not legal
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h7B:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // sv marks when p/p_prev hold real samples, so a fresh start always settles from scratch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      p      <= '0;
      p_prev <= '0;
      sv     <= '0;
    end else begin
      s1     <= seg;
      p      <= s1;
      p_prev <= p;
      sv     <= {sv[1:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hex_nxt   = hex;
    valid_nxt = valid;
    blank_nxt = blank;
    err_nxt   = err;
    upd_nxt   = 1'b0;
    dec       = decode(p);
    chg       = !sv[2] || (p != p_prev);
    if (chg) begin
      state_nxt = SETTLE;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
      blank_nxt = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      if (cnt != CNT_MAX) cnt_nxt = cnt + 4'd1;
      // the counter reaches STABLE_CYCLES on this same edge, so the lock lands at S+3 edges
      if (state == SETTLE && cnt == LOCK_AT) begin
        state_nxt = LOCKED;
        if (dec[4]) begin
          hex_nxt   = dec[3:0];
          valid_nxt = 1'b1;
          upd_nxt   = (dec[3:0] != hex);
        end else if (p == 7'h00) begin
          blank_nxt = 1'b1;
        end else begin
          err_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      cnt   <= '0;
      hex   <= '0;
      valid <= 1'b0;
      blank <= 1'b0;
      err   <= 1'b0;
      upd   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hex   <= hex_nxt;
      valid <= valid_nxt;
      blank <= blank_nxt;
      err   <= err_nxt;
      upd   <= upd_nxt;
    end
  end

`ifdef SEG7_DECODE_ERRCNT_EN
  // err only rises from 0 on an illegal lock edge, since any change clears it first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_nxt && !err && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_decode.sv
// Directed table-driven bench for seg7_decode, plus hand sequences for latency, toggling, reset and saturation.
module tb_seg7_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] hex;
  logic       valid, blank, err, upd;
`ifdef SEG7_DECODE_ERRCNT_EN
  logic [1:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;

  seg7_decode #(.STABLE_CYCLES(4), .ERR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg   (seg),
    .hex   (hex),
    .valid (valid),
    .blank (blank),
    .err   (err),
    .upd   (upd)
`ifdef SEG7_DECODE_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd) upd_cnt++;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] hex;
    logic       valid;
    logic       blank;
    logic       err;
    int         upds;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[18];
  int   u0;
  int   bad_cyc;

  initial begin
    vecs[0]  = '{7'h3F, 4'h0, 1, 0, 0, 0};
    vecs[1]  = '{7'h5B, 4'h2, 1, 0, 0, 1};
    vecs[2]  = '{7'h12, 4'h2, 0, 0, 1, 0};
    vecs[3]  = '{7'h00, 4'h2, 0, 1, 0, 0};
    vecs[4]  = '{7'h77, 4'hA, 1, 0, 0, 1};
    vecs[5]  = '{7'h7C, 4'hB, 1, 0, 0, 1};
    vecs[6]  = '{7'h39, 4'hC, 1, 0, 0, 1};
    vecs[7]  = '{7'h5E, 4'hD, 1, 0, 0, 1};
    vecs[8]  = '{7'h7B, 4'hE, 1, 0, 0, 1};
    vecs[9]  = '{7'h71, 4'hF, 1, 0, 0, 1};
    vecs[10] = '{7'h06, 4'h1, 1, 0, 0, 1};
    vecs[11] = '{7'h4F, 4'h3, 1, 0, 0, 1};
    vecs[12] = '{7'h66, 4'h4, 1, 0, 0, 1};
    vecs[13] = '{7'h6D, 4'h5, 1, 0, 0, 1};
    vecs[14] = '{7'h7D, 4'h6, 1, 0, 0, 1};
    vecs[15] = '{7'h07, 4'h7, 1, 0, 0, 1};
    vecs[16] = '{7'h7F, 4'h8, 1, 0, 0, 1};
    vecs[17] = '{7'h6F, 4'h9, 1, 0, 0, 1};

    seg   = 7'h3F;
    rst_n = 1'b0;
    #2;
    check("rst_hex", 32'(hex), 0);
    check("rst_flags", {valid, blank, err, upd}, 0);
`ifdef SEG7_DECODE_ERRCNT_EN
    check("rst_errcnt", 32'(err_cnt), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      seg = vecs[i].seg;
      u0  = upd_cnt;
      repeat (12) @(posedge clk);
      #1;
      check($sformatf("v%0d_hex", i), 32'(hex), 32'(vecs[i].hex));
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_blank", i), 32'(blank), 32'(vecs[i].blank));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("v%0d_upd", i), 32'(upd_cnt - u0), 32'(vecs[i].upds));
    end
`ifdef SEG7_DECODE_ERRCNT_EN
    check("errcnt_one", 32'(err_cnt), 1);
`endif

    // long hold on E: one update, then nothing more
    @(negedge clk);
    seg = 7'h7B;
    u0  = upd_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("hold_hex", 32'(hex), 32'hE);
    check("hold_upd", 32'(upd_cnt - u0), 1);

    // fast toggling never locks
    u0 = upd_cnt;
    bad_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 3 == 0) seg = ((i / 3) % 2 == 0) ? 7'h06 : 7'h3F;
      if (i >= 4 && (valid || blank || err)) bad_cyc++;
    end
    check("toggle_flags", 32'(bad_cyc), 0);
    check("toggle_upd", 32'(upd_cnt - u0), 0);
    check("toggle_hex", 32'(hex), 32'hE);

    // exact latency from change to lock, starting from a blank lock
    seg = 7'h00;
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    check("lat_blank", 32'(blank), 1);
    @(negedge clk);
    seg = 7'h5B;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) check("lat_blank_e2", 32'(blank), 1);
      if (e == 3) check("lat_blank_e3", 32'(blank), 0);
      if (e == 6) check("lat_e6", {valid, upd}, 0);
      if (e == 7) check("lat_e7", {valid, upd, hex}, {1'b1, 1'b1, 4'h2});
      if (e == 8) check("lat_e8_upd", 32'(upd), 0);
    end

    // async reset while locked on F, then fresh relock
    @(negedge clk);
    seg = 7'h71;
    repeat (12) @(posedge clk);
    #1;
    check("pre_rst", {valid, hex}, {1'b1, 4'hF});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst", {valid, hex}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 6) check("relock_e6", 32'(valid), 0);
      if (e == 7) check("relock_e7", {valid, upd, hex}, {1'b1, 1'b1, 4'hF});
    end

`ifdef SEG7_DECODE_ERRCNT_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      seg = 7'h12 + 7'(k);
      repeat (12) @(negedge clk);
      seg = 7'h06;
      repeat (12) @(negedge clk);
      if (k == 1) check("errcnt_two", 32'(err_cnt), 2);
    end
    check("errcnt_sat", 32'(err_cnt), 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
